mips_pipeline_ctrl: RTL and testbench

Parametrised run-control and hazard unit for the five-stage MIPS pipeline. It replaces the hard-wired `in_pc_enable(1)` of the current datapath and generates the following stage-level controls:
- PC enable, IF/ID enable, a per-stage flush vector and a global pipeline enable.
- Run, single-step and halt-drain modes.
- Load-use stall detection and control-redirect flush.
- A saturating cycle counter.

It sits beside the datapath top and drives every pipeline register's enable/flush input.

---
 rtl/mips_pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_pipeline_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline_ctrl.sv
// Run-control and hazard unit for the five-stage MIPS pipeline: generates the
// PC / IF/ID / global enables, per-stage flushes and an enabled-cycle counter.
module mips_pipeline_ctrl #(
  parameter int LEN          = 32,
  parameter int NB           = 5,
  parameter int FLUSH_W      = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_start,
  input  logic               in_step,
  input  logic               in_halt,
  input  logic [NB-1:0]      in_id_rs,
  input  logic [NB-1:0]      in_id_rt,
  input  logic               in_ex_mem_read,
  input  logic [NB-1:0]      in_ex_rt,
  input  logic               in_redirect,
  output logic               out_pipe_enable,
  output logic               out_pc_enable,
  output logic               out_if_id_enable,
  output logic [FLUSH_W-1:0] out_flush,
  output logic               out_running,
  output logic               out_halted,
  output logic [LEN-1:0]     out_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_e;

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  // Flush masks: bit 0 squashes IF/ID, bit 1 injects a bubble into ID/EX.
  localparam logic [FLUSH_W-1:0] FLUSH_IF_ID = FLUSH_W'(1);
  localparam logic [FLUSH_W-1:0] FLUSH_ID_EX = FLUSH_W'(2);

  state_e         state_q, state_d;
  logic           step_prev_q;
  logic [DCW-1:0] drain_q, drain_d;
  logic [LEN-1:0] count_q;
  logic           running_q, halted_q;

  logic load_use;
  logic step_rise;
  logic active;
  logic halt_accept;

  assign load_use = in_ex_mem_read && (in_ex_rt != '0) &&
                    ((in_ex_rt == in_id_rs) || (in_ex_rt == in_id_rt));
  assign step_rise   = in_step && !step_prev_q;
  assign active      = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
  assign halt_accept = ((state_q == S_RUN) || (state_q == S_STEP)) &&
                       !in_redirect && !load_use && in_halt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      step_prev_q <= 1'b0;
      drain_q     <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= in_step;
      drain_q     <= drain_d;
      running_q   <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
      halted_q    <= (state_d == S_HALTED);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_start)       state_d = S_RUN;
        else if (step_rise) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt_accept) state_d = S_DRAIN;
      end
      S_STEP: begin
        state_d = halt_accept ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (in_redirect)                 state_d = S_RUN;
        else if (drain_q <= DCW'(1))     state_d = S_HALTED;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (halt_accept) begin
      drain_d = DCW'(DRAIN_CYCLES);
    end else if ((state_q == S_DRAIN) && (drain_q != '0)) begin
      drain_d = drain_q - DCW'(1);
    end
  end

  always_comb begin
    out_pipe_enable  = 1'b0;
    out_pc_enable    = 1'b0;
    out_if_id_enable = 1'b0;
    out_flush        = '0;
    if (active) begin
      out_pipe_enable  = 1'b1;
      out_pc_enable    = 1'b1;
      out_if_id_enable = 1'b1;
      if (state_q == S_DRAIN) begin
        out_pc_enable = 1'b0;
        out_flush     = FLUSH_IF_ID;
      end
      // Redirect outranks load-use: the target must load even if a stall was due.
      if (in_redirect) begin
        out_pc_enable = 1'b1;
        out_flush     = '1;
      end else if (load_use) begin
        out_pc_enable    = 1'b0;
        out_if_id_enable = 1'b0;
        out_flush        = out_flush | FLUSH_ID_EX;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (out_pipe_enable && (count_q != '1)) begin
      count_q <= count_q + LEN'(1);
    end
  end

  assign out_running     = running_q;
  assign out_halted      = halted_q;
  assign out_cycle_count = count_q;

endmodule

// File: tb/tb_mips_pipeline_ctrl.sv
// Scoreboard bench for mips_pipeline_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against two DUTs.
module tb_mips_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_start, in_step, in_halt;
  logic [4:0] in_id_rs, in_id_rt, in_ex_rt;
  logic       in_ex_mem_read, in_redirect;

  logic        pipe_en, pc_en, if_id_en, running, halted;
  logic [2:0]  flush;
  logic [31:0] cycle_count;
  logic        pipe_en4, pc_en4, if_id_en4, running4, halted4;
  logic [2:0]  flush4;
  logic [3:0]  cycle_count4;

  always #5 clk = ~clk;

  mips_pipeline_ctrl u_dut (
    .clk(clk), .reset(reset), .in_start(in_start), .in_step(in_step), .in_halt(in_halt),
    .in_id_rs(in_id_rs), .in_id_rt(in_id_rt), .in_ex_mem_read(in_ex_mem_read),
    .in_ex_rt(in_ex_rt), .in_redirect(in_redirect),
    .out_pipe_enable(pipe_en), .out_pc_enable(pc_en), .out_if_id_enable(if_id_en),
    .out_flush(flush), .out_running(running), .out_halted(halted),
    .out_cycle_count(cycle_count)
  );

  mips_pipeline_ctrl #(.LEN(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_start(in_start), .in_step(in_step), .in_halt(in_halt),
    .in_id_rs(in_id_rs), .in_id_rt(in_id_rt), .in_ex_mem_read(in_ex_mem_read),
    .in_ex_rt(in_ex_rt), .in_redirect(in_redirect),
    .out_pipe_enable(pipe_en4), .out_pc_enable(pc_en4), .out_if_id_enable(if_id_en4),
    .out_flush(flush4), .out_running(running4), .out_halted(halted4),
    .out_cycle_count(cycle_count4)
  );

  typedef struct packed {
    logic [7:0]  ctl;   // {pipe, pc, if_id, flush[2:0], running, halted}
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    exp_cnt   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, "/ctl"}, {24'b0, pipe_en, pc_en, if_id_en, flush, running, halted},
            {24'b0, e.ctl});
      check({nm, "/cnt"}, cycle_count, e.cnt);
      check({nm, "/ctl4"}, {24'b0, pipe_en4, pc_en4, if_id_en4, flush4, running4, halted4},
            {24'b0, e.ctl});
      check({nm, "/cnt4"}, {28'b0, cycle_count4}, {28'b0, e.cnt4});
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic pipe, input logic pc, input logic ifid,
                     input logic [2:0] fl, input logic run, input logic hlt);
    exp_t e;
    e.ctl  = {pipe, pc, ifid, fl, run, hlt};
    e.cnt  = 32'(exp_cnt);
    e.cnt4 = (exp_cnt > 15) ? 4'hF : 4'(exp_cnt);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (pipe) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_c(input string nm);    cyc(nm, 1, 1, 1, 3'b000, 1, 0); endtask
  task automatic idle_c(input string nm);   cyc(nm, 0, 0, 0, 3'b000, 0, 0); endtask
  task automatic drain_c(input string nm);  cyc(nm, 1, 0, 1, 3'b001, 1, 0); endtask
  task automatic halted_c(input string nm); cyc(nm, 0, 0, 0, 3'b000, 0, 1); endtask

  initial begin
    reset = 1'b0;
    in_start = 0; in_step = 0; in_halt = 0; in_redirect = 0; in_ex_mem_read = 0;
    in_id_rs = '0; in_id_rt = '0; in_ex_rt = '0;
    #1;
    idle_c("reset");
    idle_c("reset2");
    reset = 1'b1;
    idle_c("idle");

    in_start = 1; idle_c("start_req"); in_start = 0;
    for (int i = 0; i < 10; i++) run_c("run");

    in_ex_mem_read = 1; in_ex_rt = 5; in_id_rs = 5;
    cyc("lu_rs", 1, 0, 0, 3'b010, 1, 0);
    in_ex_rt = 0; in_id_rs = 0;
    run_c("lu_rt_zero");
    in_ex_rt = 7; in_id_rs = 3; in_id_rt = 7;
    cyc("lu_rt", 1, 0, 0, 3'b010, 1, 0);
    in_ex_mem_read = 0;
    run_c("no_load");
    in_ex_mem_read = 1; in_ex_rt = 5; in_id_rs = 5; in_id_rt = 0; in_redirect = 1;
    cyc("redir_over_lu", 1, 1, 1, 3'b111, 1, 0);
    in_redirect = 0; in_halt = 1;
    cyc("lu_over_halt", 1, 0, 0, 3'b010, 1, 0);
    in_ex_mem_read = 0; in_ex_rt = 0; in_id_rs = 0;
    run_c("halt_accept");
    for (int i = 0; i < 4; i++) drain_c("drain");
    in_halt = 0; in_start = 1;
    halted_c("halted");
    in_start = 0;
    halted_c("halted2");

    reset = 0; exp_cnt = 0; idle_c("rst_halted"); reset = 1;
    in_start = 1; idle_c("start2"); in_start = 0;
    run_c("run2");
    in_halt = 1; run_c("halt2_accept"); in_halt = 0;
    drain_c("drain2_1");
    in_redirect = 1; cyc("drain_redirect", 1, 1, 1, 3'b111, 1, 0); in_redirect = 0;
    run_c("post_squash");
    run_c("post_squash2");
    in_halt = 1; run_c("halt3_accept"); in_halt = 0;
    drain_c("drain3_1");
    reset = 0; exp_cnt = 0; idle_c("rst_mid_drain"); reset = 1;
    idle_c("idle3");

    in_step = 1;
    idle_c("step_rise");
    cyc("step", 1, 1, 1, 3'b000, 1, 0);
    for (int i = 0; i < 3; i++) idle_c("step_held");
    in_step = 0; idle_c("step_low");
    in_step = 1; idle_c("step_rise2");
    cyc("step2", 1, 1, 1, 3'b000, 1, 0);
    idle_c("after_step2");
    in_step = 0; idle_c("step_low2");
    in_step = 1; in_halt = 1; idle_c("step_rise3");
    cyc("step_halt", 1, 1, 1, 3'b000, 1, 0);
    in_step = 0; in_halt = 0;
    for (int i = 0; i < 4; i++) drain_c("step_drain");
    halted_c("step_halted");

    reset = 0; exp_cnt = 0; idle_c("rst3"); reset = 1;
    in_start = 1; idle_c("start4"); in_start = 0;
    for (int i = 0; i < 20; i++) run_c("run_sat");
    run_c("sat_final");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
